aes_pipe_scheduler: RTL and testbench
=====================================

// Module: aes_pipe_scheduler
// PURPOSE
//  Shares one fixed-latency pipelined AES encryption core (round_0 + round stages) between NUM_REQ requesters.
//  - Round-robin arbitration selects one block per cycle and drives the core's enable/IN.
//  - A sideband shift register tracks each block's source/tag through the core.
//  - Results land in an output FIFO. Issue is credit-limited so the non-stallable core never overflows it.
//  - Supports a graceful drain handshake.
// PARAMETERS
//  BLOCK_LENGTH  128  data width of core IN/OUT
//  NUM_REQ       2    number of requesters (2..8)
//  PIPE_DEPTH    11   cycles from core enable sample to core OUT valid (11 = AES-128, 15 = AES-256)
//  TAG_W         4    per-block user tag width
//  OUT_DEPTH     4    output FIFO entries (power of 2, >=2); also the total credit pool
// PORTS
//  clk         in   1                    rising-edge clock
//  rst         in   1                    synchronous, active-low reset
//  req_valid   in   NUM_REQ              per-requester block valid
//  req_ready   out  NUM_REQ              per-requester grant (one-hot or zero)
//  req_data    in   NUM_REQ*BLOCK_LENGTH requester i at [i*BLOCK_LENGTH +: BLOCK_LENGTH]
//  req_tag     in   NUM_REQ*TAG_W        requester i at [i*TAG_W +: TAG_W]
//  core_enable out  1                    to core round_0 enable
//  core_in     out  BLOCK_LENGTH         to core round_0 IN
//  core_out    in   BLOCK_LENGTH         ciphertext from final core stage
//  rsp_valid   out  1                    output FIFO not empty (first-word fall-through)
//  rsp_ready   in   1                    consumer pop
//  rsp_data    out  BLOCK_LENGTH         ciphertext at FIFO head
//  rsp_src     out  max(1,$clog2(NUM_REQ)) originating requester index
//  rsp_tag     out  TAG_W                tag at FIFO head
//  drain       in   1                    level: stop accepting and flush
//  drain_done  out  1                    drain complete; core and FIFO empty
//  busy        out  1                    in-flight count != 0 or FIFO not empty
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - outputs: req_ready=0, core_enable=0, core_in=0, rsp_valid=0, drain_done=0, busy=0
//   - internal: sideband valid bits=0, FIFO ptrs/count=0, credit count=0, RR pointer=0, FSM=IDLE
//   - Mid-operation reset discards all in-flight blocks; core_out during the following PIPE_DEPTH cycles is ignored.
//  Credits: used = blocks in enable stage + sideband + FIFO count.
//   - Accept allowed only when used < OUT_DEPTH.
//   - Same-cycle accept + pop leaves used unchanged.
//  Arbitration: among req_valid, grant the first index at or after rr_ptr, wrapping modulo NUM_REQ.
//   - req_ready is combinational; asserted only in ACTIVE with a credit available.
//   - Handshake = req_valid & req_ready. On handshake, rr_ptr <= grant+1 (wraps NUM_REQ-1 -> 0); otherwise rr_ptr holds.
//  Latency: handshake at edge E0.
//   - core_enable=1, core_in=data registered during the cycle after E0 (core samples at E1); else core_enable=0, core_in=0.
//   - Sideband {valid,src,tag} enters at E1 and shifts PIPE_DEPTH stages.
//   - Sideband exit valid at edge E1+PIPE_DEPTH: push {core_out,src,tag} into FIFO; rsp_valid high after that edge.
//   - Handshake-to-rsp_valid = PIPE_DEPTH+1 cycles. Back-to-back accepts give one result per cycle.
//  FIFO: pop on rsp_valid & rsp_ready. Push and pop in the same cycle are both honoured, including when full or empty.
//   - Push while full cannot occur (credit rule); the bench asserts this.
//  FSM:
//   - IDLE   -> ACTIVE when any req_valid and drain=0.
//   - ACTIVE -> DRAIN when drain=1; takes precedence over a same-cycle request, so no grant that cycle.
//   - ACTIVE -> IDLE when no req_valid and busy=0.
//   - DRAIN: req_ready=0; drain_done=1 while busy=0. Leaves to IDLE when drain=0.
//   - IDLE with drain=1: drain_done=1 immediately.
// TESTING
//  - Single block: req_valid[0]=1, data=0x00112233445566778899aabbccddeeff, tag=3.
//    -> core_enable 1 cycle later; rsp_valid 12 cycles after handshake; rsp_src=0, rsp_tag=3, rsp_data=core_out.
//  - Both requesters always valid, rsp_ready=1 -> grants alternate 0,1,0,1; one rsp per cycle in issue order.
//  - rsp_ready=0, continuous requests -> exactly OUT_DEPTH=4 accepts, then req_ready=0.
//    One pop -> exactly one new accept. No overflow.
//  - drain=1 with 3 blocks in flight -> no new grants; drain_done=1 after the 3rd rsp is popped and busy=0.
//  - rst=0 for 1 cycle mid-stream -> all outputs zero next cycle; no stale rsp_valid over the following 11 cycles.
//  - NUM_REQ=3, rr_ptr=2, only req 0 and req 1 valid -> req 0 granted; next grant goes to req 1.

Source files
------------

// File: rtl/aes_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined AES core; results land in a credit-guarded FWFT FIFO.
// Handshake to core_enable: 1 cycle, to rsp_valid: PIPE_DEPTH+1 cycles; requesters stall on drain or when credits run out.
module aes_pipe_scheduler #(
    parameter int BLOCK_LENGTH = 128,
    parameter int NUM_REQ      = 2,
    parameter int PIPE_DEPTH   = 11,
    parameter int TAG_W        = 4,
    parameter int OUT_DEPTH    = 4,
    localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*BLOCK_LENGTH-1:0] req_data,
    input  logic [NUM_REQ*TAG_W-1:0]        req_tag,
    output logic                            core_enable,
    output logic [BLOCK_LENGTH-1:0]         core_in,
    input  logic [BLOCK_LENGTH-1:0]         core_out,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [BLOCK_LENGTH-1:0]         rsp_data,
    output logic [SRC_W-1:0]                rsp_src,
    output logic [TAG_W-1:0]                rsp_tag,
    input  logic                            drain,
    output logic                            drain_done,
    output logic                            busy
);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    typedef struct packed {
        logic [BLOCK_LENGTH-1:0] data;
        logic [SRC_W-1:0]        src;
        logic [TAG_W-1:0]        tag;
    } rsp_t;

    state_t              state;
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    grant_idx;
    logic                found;
    logic                accept;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    used;
    logic [SRC_W-1:0]    src_q;
    logic [TAG_W-1:0]    tag_q;
    logic [PIPE_DEPTH-1:0] sb_vld;
    logic [SRC_W-1:0]    sb_src [PIPE_DEPTH];
    logic [TAG_W-1:0]    sb_tag [PIPE_DEPTH];
    rsp_t                fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    rsp_t                head;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = SRC_W'(idx);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // used counts every block from grant until it leaves the FIFO, so the core can never overrun it.
    assign accept = found && (state == ACTIVE) && !drain && (used < CNT_W'(OUT_DEPTH));

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign rsp_valid  = (fifo_cnt != '0);
    assign pop        = rsp_valid && rsp_ready;
    assign push       = sb_vld[PIPE_DEPTH-1];
    assign busy       = (used != '0);
    assign drain_done = !busy && ((state == DRAIN) || ((state == IDLE) && drain));
    assign head       = fifo_mem[rd_ptr];
    assign rsp_data   = head.data;
    assign rsp_src    = head.src;
    assign rsp_tag    = head.tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            used        <= '0;
            core_enable <= 1'b0;
            core_in     <= '0;
            src_q       <= '0;
            tag_q       <= '0;
            sb_vld      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            case (state)
                IDLE:    if ((|req_valid) && !drain) state <= ACTIVE;
                ACTIVE:  if (drain) state <= DRAIN;
                         else if (!(|req_valid) && !busy) state <= IDLE;
                DRAIN:   if (!drain) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (accept) rr_ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            core_enable <= accept;
            core_in     <= accept ? req_data[grant_idx*BLOCK_LENGTH +: BLOCK_LENGTH] : '0;
            src_q       <= grant_idx;
            tag_q       <= req_tag[grant_idx*TAG_W +: TAG_W];
            sb_vld      <= {sb_vld[PIPE_DEPTH-2:0], core_enable};
            if (accept && !pop)      used <= used + 1'b1;
            else if (!accept && pop) used <= used - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Payload side needs no reset: only the valid bits and FIFO count qualify it.
    always_ff @(posedge clk) begin
        sb_src[0] <= src_q;
        sb_tag[0] <= tag_q;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            sb_src[k] <= sb_src[k-1];
            sb_tag[k] <= sb_tag[k-1];
        end
        if (push) fifo_mem[wr_ptr] <= '{data: core_out, src: sb_src[PIPE_DEPTH-1], tag: sb_tag[PIPE_DEPTH-1]};
    end

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Randomised bench for aes_pipe_scheduler with a stand-in pipelined core and a queue-based scoreboard.
module tb_aes_pipe_scheduler;
    localparam int BL = 128;
    localparam int NR = 2;
    localparam int PD = 11;
    localparam int TW = 4;
    localparam int OD = 4;
    localparam int S_IDLE = 0, S_ACT = 1, S_DRAIN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*BL-1:0] req_data = '0;
    logic [NR*TW-1:0] req_tag = '0;
    logic             core_enable;
    logic [BL-1:0]    core_in;
    logic [BL-1:0]    core_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [BL-1:0]    rsp_data;
    logic [0:0]       rsp_src;
    logic [TW-1:0]    rsp_tag;
    logic             drain = 1'b0;
    logic             drain_done;
    logic             busy;

    aes_pipe_scheduler #(.BLOCK_LENGTH(BL), .NUM_REQ(NR), .PIPE_DEPTH(PD), .TAG_W(TW), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_tag(req_tag), .core_enable(core_enable), .core_in(core_in), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_src(rsp_src),
        .rsp_tag(rsp_tag), .drain(drain), .drain_done(drain_done), .busy(busy));

    // Three-requester instance for the wrap-around arbitration case.
    logic          rst3 = 1'b0;
    logic [2:0]    req_valid3 = '0;
    logic [2:0]    req_ready3;
    logic [3*BL-1:0] req_data3 = '0;
    logic [3*TW-1:0] req_tag3 = '0;
    logic          core_enable3;
    logic [BL-1:0] core_in3;
    logic [BL-1:0] core_out3 = '0;
    logic          rsp_valid3;
    logic [BL-1:0] rsp_data3;
    logic [1:0]    rsp_src3;
    logic [TW-1:0] rsp_tag3;
    logic          drain_done3;
    logic          busy3;

    aes_pipe_scheduler #(.BLOCK_LENGTH(BL), .NUM_REQ(3), .PIPE_DEPTH(PD), .TAG_W(TW), .OUT_DEPTH(OD)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3), .req_data(req_data3),
        .req_tag(req_tag3), .core_enable(core_enable3), .core_in(core_in3), .core_out(core_out3),
        .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_data(rsp_data3), .rsp_src(rsp_src3),
        .rsp_tag(rsp_tag3), .drain(1'b0), .drain_done(drain_done3), .busy(busy3));

    function automatic logic [BL-1:0] enc(input logic [BL-1:0] d);
        return {d[63:0], d[127:64]} ^ 128'h5a3c_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;
    endfunction

    // Stand-in core: PD register stages; idle slots carry junk the scheduler must ignore.
    logic [BL-1:0] core_pipe [PD];
    always @(posedge clk) begin
        core_pipe[0] <= core_enable ? enc(core_in) : {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k < PD; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_out = core_pipe[PD-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [BL-1:0] got, input logic [BL-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int            src;
        logic [BL-1:0] data;
        logic [TW-1:0] tag;
        int            due;
    } blk_t;

    blk_t          flight[$];
    blk_t          outq[$];
    int            m_state = S_IDLE;
    int            m_rr = 0;
    logic          m_en = 1'b0;
    logic [BL-1:0] m_in = '0;
    int            cyc = 0;
    int            hs_count = 0;

    function automatic logic [NR*BL-1:0] rnd_data();
        logic [NR*BL-1:0] d;
        for (int k = 0; k < NR*BL/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic step(input logic r, input logic [NR-1:0] rv, input logic dr, input logic rdy,
                        input logic [NR*BL-1:0] d, input logic [NR*TW-1:0] t);
        int   used;
        int   g;
        logic can;
        logic [NR-1:0] exp_ready;
        logic ovf;
        @(negedge clk);
        rst = r; req_valid = rv; drain = dr; rsp_ready = rdy; req_data = d; req_tag = t;
        #1;
        used = flight.size() + outq.size();
        can  = (m_state == S_ACT) && !dr && (used < OD);
        g = -1;
        for (int k = 0; k < NR; k++)
            if (g < 0 && rv[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        exp_ready = '0;
        if (can && g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("core_enable", core_enable, m_en);
        check("core_in", core_in, m_in);
        check("rsp_valid", rsp_valid, outq.size() != 0);
        if (outq.size() != 0) begin
            check("rsp_data", rsp_data, outq[0].data);
            check("rsp_src", rsp_src, outq[0].src);
            check("rsp_tag", rsp_tag, outq[0].tag);
        end
        check("busy", busy, used != 0);
        check("drain_done", drain_done,
              ((m_state == S_DRAIN) || (m_state == S_IDLE && dr)) && used == 0);
        ovf = dut.sb_vld[PD-1] && (int'(dut.fifo_cnt) == OD) && !(rsp_valid && rdy);
        check("fifo_overflow", ovf, 1'b0);
        @(posedge clk);
        cyc++;
        if (!r) begin
            flight.delete(); outq.delete();
            m_state = S_IDLE; m_rr = 0; m_en = 1'b0; m_in = '0;
        end else begin
            m_en = (exp_ready != 0);
            m_in = '0;
            if (exp_ready != 0) begin
                blk_t b;
                b.src  = g;
                b.data = enc(d[g*BL +: BL]);
                b.tag  = t[g*TW +: TW];
                b.due  = cyc + PD + 1;
                flight.push_back(b);
                m_in = d[g*BL +: BL];
                m_rr = (g + 1) % NR;
                hs_count++;
            end
            case (m_state)
                S_IDLE:  if ((rv != 0) && !dr) m_state = S_ACT;
                S_ACT:   if (dr) m_state = S_DRAIN;
                         else if (rv == 0 && used == 0) m_state = S_IDLE;
                default: if (!dr) m_state = S_IDLE;
            endcase
            if (outq.size() != 0 && rdy) void'(outq.pop_front());
            while (flight.size() != 0 && flight[0].due == cyc) outq.push_back(flight.pop_front());
        end
    endtask

    initial begin
        logic [NR*BL-1:0] d1;
        logic             drv;
        int               hs0;

        // Reset state
        repeat (3) step(1'b0, 2'b00, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));

        // Single block from requester 0
        d1 = rnd_data();
        d1[BL-1:0] = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        hs0 = hs_count;
        for (int i = 0; i < 4 && hs_count == hs0; i++) step(1'b1, 2'b01, 1'b0, 1'b0, d1, 8'h03);
        check("single_accepted", hs_count - hs0, 1);
        repeat (14) step(1'b1, 2'b00, 1'b0, 1'b0, d1, 8'h03);
        repeat (3) step(1'b1, 2'b00, 1'b0, 1'b1, d1, 8'h03);

        // Both requesters always valid, consumer always ready
        repeat (30) step(1'b1, 2'b11, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));
        repeat (16) step(1'b1, 2'b00, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));

        // Credit exhaustion, then one pop frees exactly one slot
        hs0 = hs_count;
        repeat (25) step(1'b1, 2'b11, 1'b0, 1'b0, rnd_data(), NR*TW'($urandom));
        check("credit_limit", hs_count - hs0, OD);
        step(1'b1, 2'b11, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));
        repeat (6) step(1'b1, 2'b11, 1'b0, 1'b0, rnd_data(), NR*TW'($urandom));
        check("one_pop_one_accept", hs_count - hs0, OD + 1);
        repeat (20) step(1'b1, 2'b00, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));

        // Drain with three blocks in flight
        hs0 = hs_count;
        for (int i = 0; i < 8 && hs_count - hs0 < 3; i++)
            step(1'b1, 2'b01, 1'b0, 1'b0, rnd_data(), NR*TW'($urandom));
        repeat (15) step(1'b1, 2'b11, 1'b1, 1'b0, rnd_data(), NR*TW'($urandom));
        check("drain_no_grant", hs_count - hs0, 3);
        repeat (5) step(1'b1, 2'b11, 1'b1, 1'b1, rnd_data(), NR*TW'($urandom));
        check("drain_done_final", drain_done, 1'b1);
        repeat (3) step(1'b1, 2'b00, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));

        // Mid-stream reset
        repeat (16) step(1'b1, 2'b11, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));
        step(1'b0, 2'b11, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));
        repeat (14) step(1'b1, 2'b00, 1'b0, 1'b1, rnd_data(), NR*TW'($urandom));

        // Random traffic
        drv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) drv = !drv;
            step(($urandom_range(0, 399) != 0), NR'($urandom), drv, ($urandom_range(0, 3) != 0),
                 rnd_data(), NR*TW'($urandom));
        end

        // Three requesters: rr_ptr parked at 2, only 0 and 1 valid
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1; req_valid3 = 3'b010;
        #1 check("rr3_idle", req_ready3, 3'b000);
        @(negedge clk);
        #1 check("rr3_first", req_ready3, 3'b010);
        @(negedge clk);
        req_valid3 = 3'b011;
        #1 check("rr3_wrap", req_ready3, 3'b001);
        @(negedge clk);
        #1 check("rr3_next", req_ready3, 3'b010);
        @(negedge clk);
        #1 check("rr3_again", req_ready3, 3'b001);
        @(negedge clk);
        req_valid3 = 3'b000;
        #1 check("rr3_credit_out", req_ready3, 3'b000);
        check("rr3_busy", busy3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
